i2c_responder: RTL and testbench

- I2C target (slave) that answers the team's I2C configuration master, i.e. the other end of the SDA/SCL bus.
- Used as a bench/loopback stand-in for the HDMI transmitter's register port and for on-chip config capture.
- Decodes START/STOP, matches a 7-bit device address, and accepts sub-address plus data writes into an internal register file with auto-increment.
- Supports reads via repeated START and reports every register write on a strobe interface.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 38 +++
 rtl/i2c_responder.sv | 174 +++++++++++++++++
 tb/tb_i2c_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants for the responder and the config master
package i2c_pkg;

  localparam int   BYTE_W = 8;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - 2-FF synchronizer, hold filter and edge detector for one I2C line
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0]          sync;
  logic [FILT_LEN-1:0] hist;
  logic                level_d;

  // Resets to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '1;
      hist    <= '1;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], pin};
      hist    <= FILT_LEN'({hist, sync[1]});
      if (&hist) begin
        level <= 1'b1;
      end else if (~|hist) begin
        level <= 1'b0;
      end
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_responder.sv
// rtl/i2c_responder.sv - I2C target with auto-incrementing register file and write strobe
module i2c_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         REG_AW   = 8,
  parameter int         FILT_LEN = 3
) (
  input  logic              REF_CLK,
  input  logic              RESET_RSP,
  input  logic              I2C_SCL,
  inout  wire               I2C_SDA,
  output logic              REG_WR,
  output logic [REG_AW-1:0] REG_ADDR,
  output logic [BYTE_W-1:0] REG_WDATA,
  output logic              BUSY,
  output logic              ADDR_HIT
);
  i2c_state_e        state_q, state_d;
  logic              scl, scl_rise, scl_fall;
  logic              sda, sda_rise, sda_fall;
  logic              start, stop, last_bit, addr_match;
  logic              sda_oe, rw, got_ack;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shift, in_byte, rd_byte;
  logic [REG_AW-1:0] ptr;
  logic [BYTE_W-1:0] mem [2**REG_AW];

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(REF_CLK), .rst(RESET_RSP), .pin(I2C_SCL),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(REF_CLK), .rst(RESET_RSP), .pin(I2C_SDA),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign I2C_SDA    = sda_oe ? 1'b0 : 1'bz;
  assign start      = sda_fall & scl;
  assign stop       = sda_rise & scl;
  assign last_bit   = (bit_cnt == 4'd7);
  assign in_byte    = {shift[BYTE_W-2:0], sda};
  assign addr_match = (in_byte[7:1] == DEV_ADDR);
  assign rd_byte    = mem[ptr];

  always_ff @(posedge REF_CLK or posedge RESET_RSP) begin
    if (RESET_RSP) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ACK slots use sda_oe as their phase: first SCL fall asserts, second ends the slot.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:      if (scl_rise && last_bit) state_d = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall && sda_oe) state_d = rw ? RDATA : SUB;
        SUB:       if (scl_rise && last_bit) state_d = SUB_ACK;
        SUB_ACK:   if (scl_fall && sda_oe) state_d = WDATA;
        WDATA:     if (scl_rise && last_bit) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall && sda_oe) state_d = WDATA;
        RDATA:     if (scl_fall && bit_cnt == 4'd8) state_d = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda == NACK) begin
            state_d = WAIT_STOP;
          end else if (scl_fall && got_ack) begin
            state_d = RDATA;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge REF_CLK or posedge RESET_RSP) begin
    if (RESET_RSP) begin
      sda_oe    <= 1'b0;
      rw        <= 1'b0;
      got_ack   <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      REG_WR    <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      BUSY      <= 1'b0;
      ADDR_HIT  <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++) begin
        mem[i] <= '0;
      end
    end else begin
      REG_WR   <= 1'b0;
      ADDR_HIT <= 1'b0;
      if (stop) begin
        sda_oe <= 1'b0;
        BUSY   <= 1'b0;
      end else if (start) begin
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state_q)
          ADDR, SUB, WDATA: begin
            if (scl_rise) begin
              shift   <= in_byte;
              bit_cnt <= bit_cnt + 1'b1;
              if (last_bit && state_q == ADDR && addr_match) begin
                ADDR_HIT <= 1'b1;
                BUSY     <= 1'b1;
                rw       <= in_byte[0];
              end
              if (last_bit && state_q == SUB) begin
                ptr <= in_byte[REG_AW-1:0];
              end
              if (last_bit && state_q == WDATA) begin
                mem[ptr]  <= in_byte;
                REG_WR    <= 1'b1;
                REG_ADDR  <= ptr;
                REG_WDATA <= in_byte;
                ptr       <= ptr + 1'b1;
              end
            end
          end
          ADDR_ACK, SUB_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (state_q == ADDR_ACK && rw) begin
                shift  <= rd_byte;
                sda_oe <= ~rd_byte[BYTE_W-1];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                got_ack <= 1'b0;
                ptr     <= ptr + 1'b1;
              end else begin
                shift  <= shift << 1;
                sda_oe <= ~shift[BYTE_W-2];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              got_ack <= (sda == ACK);
            end else if (scl_fall && got_ack) begin
              got_ack <= 1'b0;
              bit_cnt <= '0;
              shift   <= rd_byte;
              sda_oe  <= ~rd_byte[BYTE_W-1];
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// tb/tb_i2c_responder.sv - self-checking bench for i2c_responder with a bus-level register model
module tb_i2c_responder;
  import i2c_pkg::*;

  localparam int Q = 10;

  typedef struct {
    logic [7:0]  dev;
    logic [7:0]  sub;
    int          n;
    logic [31:0] data;
    logic        exp_ack;
    int          exp_nwr;
  } wr_vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_line;
  logic       reg_wr, busy, addr_hit;
  logic [7:0] reg_addr, reg_wdata;

  int          tests = 0;
  int          failed = 0;
  int          hit_cnt = 0;
  int          dut_low_cnt = 0;
  logic [7:0]  model [256];
  logic [15:0] wrq [$];
  wr_vec_t     vecs [6];

  assign sda_line = m_sda ? 1'bz : 1'b0;
  pullup (sda_line);

  always #10 clk = ~clk;

  i2c_responder dut (
    .REF_CLK(clk), .RESET_RSP(rst), .I2C_SCL(scl), .I2C_SDA(sda_line),
    .REG_WR(reg_wr), .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata),
    .BUSY(busy), .ADDR_HIT(addr_hit)
  );

  always @(negedge clk) begin
    if (reg_wr) wrq.push_back({reg_addr, reg_wdata});
    if (addr_hit) hit_cnt++;
    if (m_sda && sda_line == 1'b0) dut_low_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    m_sda = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    m_sda = 1'b1; wait_q(); wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  task automatic do_write(input logic [7:0] dev, input logic [7:0] sub, input int n,
                          input logic [31:0] data, input logic exp_ack, input int exp_nwr);
    logic        a;
    logic [7:0]  p;
    int          h0, l0;
    logic [15:0] exp_q [$];
    h0 = hit_cnt;
    l0 = dut_low_cnt;
    wrq.delete();
    i2c_start();
    write_byte(dev, a);
    check("addr_ack", a, exp_ack);
    check("busy_addr", busy, exp_ack == ACK);
    write_byte(sub, a);
    check("sub_ack", a, exp_ack);
    for (int i = 0; i < n; i++) begin
      write_byte(data[8*i +: 8], a);
      check("data_ack", a, exp_ack);
      if (exp_ack == ACK) begin
        p = sub + 8'(i);
        model[p] = data[8*i +: 8];
        exp_q.push_back({p, data[8*i +: 8]});
      end
    end
    i2c_stop();
    check("busy_stop", busy, 1'b0);
    check("hit_count", hit_cnt - h0, (exp_ack == ACK) ? 1 : 0);
    if (exp_ack == NACK) check("silent", dut_low_cnt - l0, 0);
    check("wr_count", wrq.size(), exp_nwr);
    for (int i = 0; i < exp_q.size() && i < wrq.size(); i++) check("wr_rec", wrq[i], exp_q[i]);
  endtask

  task automatic do_read(input logic [7:0] sub, input int n);
    logic       a;
    logic [7:0] d;
    wrq.delete();
    i2c_start();
    write_byte(8'h72, a);
    check("rd_addr_ack", a, ACK);
    write_byte(sub, a);
    check("rd_sub_ack", a, ACK);
    i2c_start();
    check("busy_rstart", busy, 1'b1);
    write_byte(8'h73, a);
    check("rd_addr2_ack", a, ACK);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1) ? NACK : ACK);
      check("rd_data", d, model[8'(sub + 8'(i))]);
    end
    check("rd_release", sda_line, 1'b1);
    i2c_stop();
    check("rd_no_wr", wrq.size(), 0);
    check("rd_busy_stop", busy, 1'b0);
  endtask

  initial begin
    logic       a;
    logic [7:0] dev, sub;
    int         h0, n;

    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    vecs[0] = '{8'h72, 8'h41, 1, 32'h0000_0010, ACK, 1};
    vecs[1] = '{8'h74, 8'h55, 2, 32'h0000_3C5A, NACK, 0};
    vecs[2] = '{8'h72, 8'hFE, 3, 32'h00CC_BBAA, ACK, 3};
    vecs[3] = '{8'h00, 8'h12, 1, 32'h0000_005A, NACK, 0};
    vecs[4] = '{8'h72, 8'hFF, 2, 32'h0000_0201, ACK, 2};
    vecs[5] = '{8'h72, 8'h42, 4, 32'h7788_99E5, ACK, 4};

    repeat (5) @(negedge clk);
    check("rst_sda", sda_line, 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_addr_hit", addr_hit, 1'b0);
    check("rst_state", dut.state_q, IDLE);

    for (int v = 0; v < 6; v++)
      do_write(vecs[v].dev, vecs[v].sub, vecs[v].n, vecs[v].data, vecs[v].exp_ack, vecs[v].exp_nwr);

    do_read(8'h41, 2);
    do_read(8'hFE, 3);

    // STOP after four bits of a data byte
    wrq.delete();
    i2c_start();
    write_byte(8'h72, a);
    write_byte(8'h30, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    check("partial_no_wr", wrq.size(), 0);
    check("partial_busy", busy, 1'b0);
    check("partial_idle", dut.state_q, IDLE);

    // START coinciding with an SCL rise, mid data byte
    wrq.delete();
    h0 = hit_cnt;
    i2c_start();
    write_byte(8'h72, a);
    write_byte(8'h60, a);
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    m_sda = 1'b0;
    scl = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
    check("glitch_busy", busy, 1'b1);
    write_byte(8'h72, a);
    check("glitch_addr_ack", a, ACK);
    write_byte(8'h61, a);
    write_byte(8'h99, a);
    check("glitch_data_ack", a, ACK);
    i2c_stop();
    model[8'h61] = 8'h99;
    check("glitch_hits", hit_cnt - h0, 2);
    check("glitch_wr_count", wrq.size(), 1);
    if (wrq.size() > 0) check("glitch_wr_rec", wrq[0], 16'h6199);

    // Reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h72 >> i));
    m_sda = 1'b1;
    @(negedge clk);
    check("ack_driven", sda_line, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_release", sda_line, 1'b1);
    check("rst_async_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    i2c_stop();
    do_write(8'h72, 8'h20, 1, 32'h0000_005C, ACK, 1);
    do_read(8'h1F, 2);

    for (int k = 0; k < 12; k++) begin
      sub = 8'($urandom_range(0, 255));
      if (k % 4 == 0) sub = 8'($urandom_range(252, 255));
      if ($urandom_range(0, 2) != 0) begin
        n   = $urandom_range(1, 4);
        dev = ($urandom_range(0, 5) == 0) ? {7'($urandom_range(0, 127)), 1'b0} : 8'h72;
        a   = (dev[7:1] == 7'h39) ? ACK : NACK;
        do_write(dev, sub, n, $urandom, a, (a == ACK) ? n : 0);
      end else begin
        do_read(sub, $urandom_range(1, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
